// File: rtl/mem_hazard_scheduler_pkg.sv
// Shared types and constants for the memory hazard scheduler.
//   state_t         : sequencer states (idle, instruction fetch, data access)
//   DATA_W          : RAM / instruction data width
//   NOP             : canonical RV32I no-op (addi x0, x0, 0)
//   DEFAULT_TIMEOUT : cycles an access may stay un-acked before abort
package mem_hazard_scheduler_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 64;
    localparam logic [DATA_W-1:0] NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_hazard_scheduler_fetch_buffer.sv
// One-entry instruction buffer between the RAM port and IF/ID.
//   clk, rst_n : clock, async active-low reset
//   fill       : load fill_data and mark valid
//   consume    : IF/ID took the instruction; mark empty
//   flush      : discard contents (wins over fill and consume)
//   valid      : buffer holds an instruction
//   data       : buffered instruction (NOP after a flush)
module mem_hazard_scheduler_fetch_buffer
    import mem_hazard_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              consume,
    input  logic              flush,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Fill and consume never coincide: a fetch is only issued while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= NOP;
        end else if (fill) begin
            valid <= 1'b1;
            data  <= fill_data;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_hazard_scheduler.sv
// Single-port memory sequencer and load-use hazard unit for the 5-stage core.
// Arbitrates the unified RAM between instruction fetch and MEM-stage data
// accesses (data first), buffers one fetched instruction and drives the
// pipeline hold / bubble / PC-write controls.
//   clk, rst_n                   : clock, async active-low reset
//   pc                           : fetch address
//   mem_req/we/addr/wdata        : MEM-stage load/store request
//   branch_flush                 : taken branch resolved this cycle
//   ID_EX_MemRead/RegisterRd     : load in ID/EX and its destination
//   IF_ID_RegisterRs1/Rs2        : decode-stage sources
//   ram_req/we/addr/wdata        : registered RAM command, held until ack
//   ram_ack, ram_rdata           : RAM completion and read data
//   instr                        : buffered instruction for IF/ID
//   mem_rdata, mem_done          : load data with one-cycle done pulse
//   pc_write, if_id_write        : PC / IF/ID advance
//   if_id_bubble, id_ex_bubble   : NOP insertion
//   pipe_hold                    : freeze ID/EX, EX/MEM, MEM/WB
//   bus_err                      : sticky access-timeout flag
module mem_hazard_scheduler
    import mem_hazard_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned TO_W    = 7
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              branch_flush,
    input  logic              ID_EX_MemRead,
    input  logic [4:0]        ID_EX_RegisterRd,
    input  logic [4:0]        IF_ID_RegisterRs1,
    input  logic [4:0]        IF_ID_RegisterRs2,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_bubble,
    output logic              id_ex_bubble,
    output logic              pipe_hold,
    output logic              bus_err
);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            drop;
    logic            buf_valid;
    logic            fetch_ack;
    logic            data_ack;
    logic            timed_out;
    logic            load_use;
    logic            mem_stall;
    logic            buf_fill;
    logic            advance;

    assign fetch_ack = (state == ST_FETCH) && ram_ack;
    assign data_ack  = (state == ST_DATA)  && ram_ack;
    assign timed_out = (state != ST_IDLE) && !ram_ack
                       && (to_cnt == TO_W'(TIMEOUT - 1));

    assign load_use  = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0)
                       && ((ID_EX_RegisterRd == IF_ID_RegisterRs1)
                           || (ID_EX_RegisterRd == IF_ID_RegisterRs2));
    assign mem_stall = mem_req && !data_ack;

    // A fetch result is discarded if a flush hit while in flight or in the ack cycle.
    assign buf_fill  = fetch_ack && !drop && !branch_flush;
    assign advance   = buf_valid && !mem_stall && !load_use && !branch_flush;

    // Pipeline controls are forced quiet while reset is asserted.
    assign pc_write     = rst_n && advance;
    assign if_id_write  = rst_n && advance;
    assign if_id_bubble = rst_n && !mem_stall
                          && (branch_flush || (!buf_valid && !load_use));
    assign id_ex_bubble = rst_n && load_use && !mem_stall;
    assign pipe_hold    = rst_n && mem_stall;

    // Load data is passed straight through in the ack cycle.
    assign mem_done  = data_ack;
    assign mem_rdata = data_ack ? ram_rdata : '0;

    mem_hazard_scheduler_fetch_buffer u_fetch_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill      (buf_fill),
        .fill_data (ram_rdata),
        .consume   (advance),
        .flush     (branch_flush),
        .valid     (buf_valid),
        .data      (instr)
    );

    // Access sequencer: issue from IDLE, complete or abort back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            to_cnt    <= '0;
            drop      <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    drop   <= 1'b0;
                    if (mem_req) begin
                        state     <= ST_DATA;
                        ram_req   <= 1'b1;
                        ram_we    <= mem_we;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                    end else if (!buf_valid && !branch_flush) begin
                        state     <= ST_FETCH;
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= pc;
                        ram_wdata <= '0;
                    end
                end
                ST_FETCH, ST_DATA: begin
                    if (ram_ack || timed_out) begin
                        state   <= ST_IDLE;
                        ram_req <= 1'b0;
                        ram_we  <= 1'b0;
                        to_cnt  <= '0;
                        drop    <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                        if ((state == ST_FETCH) && branch_flush) begin
                            drop <= 1'b1;
                        end
                    end
                    if (timed_out) begin
                        bus_err <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ram_req <= 1'b0;
                    ram_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_hazard_scheduler.sv
// Directed self-checking bench for mem_hazard_scheduler.
// Inputs change 2 time units after each rising edge; outputs are sampled
// 4 units after the edge. A small RAM model acks after a programmable latency.
module tb_mem_hazard_scheduler;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned TO_W    = 4;
    localparam logic [31:0] NOP_I   = 32'h0000_0013;
    localparam logic [31:0] I0      = 32'h0050_0093;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] pc;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              branch_flush;
    logic              ID_EX_MemRead;
    logic [4:0]        ID_EX_RegisterRd;
    logic [4:0]        IF_ID_RegisterRs1;
    logic [4:0]        IF_ID_RegisterRs2;
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_ack = 1'b0;
    logic [31:0]       ram_rdata;
    logic [31:0]       instr;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              pc_write;
    logic              if_id_write;
    logic              if_id_bubble;
    logic              id_ex_bubble;
    logic              pipe_hold;
    logic              bus_err;

    int errors = 0;
    int checks = 0;

    logic ack_en  = 1'b1;
    int   ack_lat = 0;
    int   req_age = 0;

    mem_hazard_scheduler #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc                (pc),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .branch_flush      (branch_flush),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_RegisterRd  (ID_EX_RegisterRd),
        .IF_ID_RegisterRs1 (IF_ID_RegisterRs1),
        .IF_ID_RegisterRs2 (IF_ID_RegisterRs2),
        .ram_req           (ram_req),
        .ram_we            (ram_we),
        .ram_addr          (ram_addr),
        .ram_wdata         (ram_wdata),
        .ram_ack           (ram_ack),
        .ram_rdata         (ram_rdata),
        .instr             (instr),
        .mem_rdata         (mem_rdata),
        .mem_done          (mem_done),
        .pc_write          (pc_write),
        .if_id_write       (if_id_write),
        .if_id_bubble      (if_id_bubble),
        .id_ex_bubble      (id_ex_bubble),
        .pipe_hold         (pipe_hold),
        .bus_err           (bus_err)
    );

    always #5 clk = ~clk;

    // RAM model: ack in the cycle where the request has been seen ack_lat+1 times.
    always @(posedge clk) begin
        #1;
        if (ram_req) req_age = req_age + 1;
        else         req_age = 0;
        ram_ack = ram_req && ack_en && (req_age > ack_lat);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ram_req"},      32'(ram_req),      32'd0);
        check({tag, "_ram_we"},       32'(ram_we),       32'd0);
        check({tag, "_ram_addr"},     ram_addr,          32'd0);
        check({tag, "_ram_wdata"},    ram_wdata,         32'd0);
        check({tag, "_instr"},        instr,             32'd0);
        check({tag, "_mem_rdata"},    mem_rdata,         32'd0);
        check({tag, "_mem_done"},     32'(mem_done),     32'd0);
        check({tag, "_pc_write"},     32'(pc_write),     32'd0);
        check({tag, "_if_id_write"},  32'(if_id_write),  32'd0);
        check({tag, "_if_id_bubble"}, 32'(if_id_bubble), 32'd0);
        check({tag, "_id_ex_bubble"}, 32'(id_ex_bubble), 32'd0);
        check({tag, "_pipe_hold"},    32'(pipe_hold),    32'd0);
        check({tag, "_bus_err"},      32'(bus_err),      32'd0);
    endtask

    // Leaves the bench at the sample point of cycle 0 (first cycle out of reset).
    task automatic apply_reset(input int lat);
        rst_n             = 1'b0;
        pc                = 32'h0000_0100;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        branch_flush      = 1'b0;
        ID_EX_MemRead     = 1'b0;
        ID_EX_RegisterRd  = 5'd0;
        IF_ID_RegisterRs1 = 5'd0;
        IF_ID_RegisterRs2 = 5'd0;
        ram_rdata         = I0;
        ack_en            = 1'b1;
        ack_lat           = lat;
        repeat (2) @(posedge clk);
        #2;
        check_quiet("rst");
        rst_n = 1'b1;
        #2;
    endtask

    task automatic hazard_case(input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic stall);
        apply_reset(0);
        next_cycle(); #2;
        next_cycle();
        ID_EX_MemRead     = 1'b1;
        ID_EX_RegisterRd  = rd;
        IF_ID_RegisterRs1 = rs1;
        IF_ID_RegisterRs2 = rs2;
        #2;
        check("lu_id_ex_bubble", 32'(id_ex_bubble), 32'(stall));
        check("lu_pc_write",     32'(pc_write),     32'(!stall));
        check("lu_if_id_write",  32'(if_id_write),  32'(!stall));
        check("lu_if_id_bubble", 32'(if_id_bubble), 32'd0);
        next_cycle();
        ID_EX_MemRead = 1'b0;
        #2;
        check("lu_next_pc_write",     32'(pc_write),     32'(stall));
        check("lu_next_id_ex_bubble", 32'(id_ex_bubble), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        // Fetch path, ack in the first request cycle.
        apply_reset(0);
        check("f_c0_if_id_bubble", 32'(if_id_bubble), 32'd1);
        check("f_c0_ram_req",      32'(ram_req),      32'd0);
        next_cycle(); #2;
        check("f_c1_ram_req",  32'(ram_req),  32'd1);
        check("f_c1_ram_addr", ram_addr,      32'h0000_0100);
        check("f_c1_ram_we",   32'(ram_we),   32'd0);
        check("f_c1_pc_write", 32'(pc_write), 32'd0);
        next_cycle(); #2;
        check("f_c2_instr",        instr,             I0);
        check("f_c2_pc_write",     32'(pc_write),     32'd1);
        check("f_c2_if_id_write",  32'(if_id_write),  32'd1);
        check("f_c2_if_id_bubble", 32'(if_id_bubble), 32'd0);
        check("f_c2_ram_req",      32'(ram_req),      32'd0);
        next_cycle(); #2;
        check("f_c3_ram_req",      32'(ram_req),      32'd0);
        check("f_c3_if_id_bubble", 32'(if_id_bubble), 32'd1);
        next_cycle(); #2;
        check("f_c4_ram_req", 32'(ram_req), 32'd1);

        // Load arrives while a fetch is in flight.
        apply_reset(1);
        next_cycle();
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_2000;
        #2;
        check("d_c1_pipe_hold", 32'(pipe_hold), 32'd1);
        check("d_c1_ram_addr",  ram_addr,       32'h0000_0100);
        next_cycle(); #2;
        check("d_c2_pipe_hold", 32'(pipe_hold), 32'd1);
        check("d_c2_mem_done",  32'(mem_done),  32'd0);
        next_cycle();
        ram_rdata = 32'hDEAD_BEEF;
        #2;
        check("d_c3_pipe_hold", 32'(pipe_hold), 32'd1);
        check("d_c3_pc_write",  32'(pc_write),  32'd0);
        check("d_c3_instr",     instr,          I0);
        check("d_c3_ram_req",   32'(ram_req),   32'd0);
        next_cycle(); #2;
        check("d_c4_ram_req",   32'(ram_req),   32'd1);
        check("d_c4_ram_addr",  ram_addr,       32'h0000_2000);
        check("d_c4_ram_we",    32'(ram_we),    32'd0);
        check("d_c4_mem_done",  32'(mem_done),  32'd0);
        check("d_c4_pipe_hold", 32'(pipe_hold), 32'd1);
        next_cycle(); #2;
        check("d_c5_mem_done",  32'(mem_done),  32'd1);
        check("d_c5_mem_rdata", mem_rdata,      32'hDEAD_BEEF);
        check("d_c5_pipe_hold", 32'(pipe_hold), 32'd0);
        check("d_c5_pc_write",  32'(pc_write),  32'd1);
        next_cycle();
        mem_req = 1'b0;
        #2;
        check("d_c6_mem_done",  32'(mem_done),  32'd0);
        check("d_c6_mem_rdata", mem_rdata,      32'd0);

        // Load-use detection: Rs1 match, x0 destination, Rs2 match, no match.
        hazard_case(5'd5, 5'd5, 5'd0, 1'b1);
        hazard_case(5'd0, 5'd0, 5'd0, 1'b0);
        hazard_case(5'd7, 5'd3, 5'd7, 1'b1);
        hazard_case(5'd7, 5'd3, 5'd4, 1'b0);

        // Flush during a fetch and flush in the ack cycle.
        apply_reset(2);
        next_cycle();
        branch_flush = 1'b1;
        pc           = 32'h0000_0200;
        #2;
        check("b_c1_if_id_bubble", 32'(if_id_bubble), 32'd1);
        check("b_c1_pc_write",     32'(pc_write),     32'd0);
        check("b_c1_ram_addr",     ram_addr,          32'h0000_0100);
        next_cycle();
        branch_flush = 1'b0;
        #2;
        check("b_c2_ram_req", 32'(ram_req), 32'd1);
        next_cycle(); #2;
        check("b_c3_ram_ack",      32'(ram_ack),      32'd1);
        check("b_c3_if_id_bubble", 32'(if_id_bubble), 32'd1);
        next_cycle(); #2;
        check("b_c4_pc_write",     32'(pc_write),     32'd0);
        check("b_c4_if_id_bubble", 32'(if_id_bubble), 32'd1);
        check("b_c4_instr",        instr,             NOP_I);
        check("b_c4_ram_req",      32'(ram_req),      32'd0);
        next_cycle(); #2;
        check("b_c5_ram_req",  32'(ram_req), 32'd1);
        check("b_c5_ram_addr", ram_addr,     32'h0000_0200);
        next_cycle(); #2;
        next_cycle();
        branch_flush = 1'b1;
        #2;
        check("b_c7_ram_ack",  32'(ram_ack),  32'd1);
        check("b_c7_pc_write", 32'(pc_write), 32'd0);
        next_cycle();
        branch_flush = 1'b0;
        #2;
        check("b_c8_pc_write",     32'(pc_write),     32'd0);
        check("b_c8_if_id_bubble", 32'(if_id_bubble), 32'd1);

        // RAM never acks: abort after TIMEOUT cycles, then retry.
        apply_reset(0);
        ack_en = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            next_cycle(); #2;
        end
        next_cycle(); #2;
        check("t_c8_ram_req", 32'(ram_req), 32'd1);
        check("t_c8_bus_err", 32'(bus_err), 32'd0);
        next_cycle();
        ack_en = 1'b1;
        #2;
        check("t_c9_bus_err",      32'(bus_err),      32'd1);
        check("t_c9_ram_req",      32'(ram_req),      32'd0);
        check("t_c9_pc_write",     32'(pc_write),     32'd0);
        check("t_c9_if_id_bubble", 32'(if_id_bubble), 32'd1);
        next_cycle(); #2;
        check("t_c10_ram_req",  32'(ram_req), 32'd1);
        check("t_c10_ram_addr", ram_addr,     32'h0000_0100);
        next_cycle(); #2;
        check("t_c11_instr",   instr,         I0);
        check("t_c11_bus_err", 32'(bus_err),  32'd1);

        // Asynchronous reset in the middle of a store.
        apply_reset(3);
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_3000;
        mem_wdata = 32'h1234_5678;
        #1;
        check("r_c0_pipe_hold",    32'(pipe_hold),    32'd1);
        check("r_c0_if_id_bubble", 32'(if_id_bubble), 32'd0);
        next_cycle(); #2;
        check("r_c1_ram_req",   32'(ram_req),  32'd1);
        check("r_c1_ram_we",    32'(ram_we),   32'd1);
        check("r_c1_ram_addr",  ram_addr,      32'h0000_3000);
        check("r_c1_ram_wdata", ram_wdata,     32'h1234_5678);
        check("r_c1_mem_done",  32'(mem_done), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check_quiet("mid_rst");
        mem_req = 1'b0;
        mem_we  = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #2;
        check("r_rel_ram_req",      32'(ram_req),      32'd0);
        check("r_rel_if_id_bubble", 32'(if_id_bubble), 32'd1);
        next_cycle(); #2;
        check("r_rel_fetch_req",  32'(ram_req), 32'd1);
        check("r_rel_fetch_addr", ram_addr,      32'h0000_0100);
        check("r_rel_fetch_we",   32'(ram_we),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
